// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the execute-stage sequencer: op classes, ALU operand
// select codes and the sequencer state.
package alu_ctrl_pkg;

   // Decoded instruction classes; codes 5..7 are illegal.
   localparam logic [2:0] OPC_R     = 3'd0;
   localparam logic [2:0] OPC_I     = 3'd1;
   localparam logic [2:0] OPC_LOAD  = 3'd2;
   localparam logic [2:0] OPC_STORE = 3'd3;
   localparam logic [2:0] OPC_JALR  = 3'd4;

   // rs2-side operand mux codes.
   localparam logic [1:0] RS2_SEL_PC    = 2'd0;
   localparam logic [1:0] RS2_SEL_IMM_S = 2'd1;
   localparam logic [1:0] RS2_SEL_IMM_I = 2'd2;
   localparam logic [1:0] RS2_SEL_RS2   = 2'd3;

   // rs1-side operand mux codes (3 is reserved).
   localparam logic [1:0] RS1_SEL_RS1  = 2'd0;
   localparam logic [1:0] RS1_SEL_FOUR = 2'd1;
   localparam logic [1:0] RS1_SEL_ZERO = 2'd2;

   // JALR targets always have bit 0 cleared.
   localparam logic [31:0] TARGET_MASK = ~32'h1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EX1  = 2'd1,
      ST_EX2  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // True for the reserved class codes 5..7.
   function automatic logic is_reserved_class(input logic [2:0] op_class);
      return op_class > OPC_JALR;
   endfunction

endpackage

// File: rtl/alu_exec_sel_decode.sv
// Combinational decode of (state, latched op class) into ALU operand selects
// and the capture strobes used by the sequencer's result registers.
module alu_exec_sel_decode
   import alu_ctrl_pkg::*;
#(
   parameter bit ILLEGAL_EN = 1'b1
) (
   input  state_e     state,
   input  logic [2:0] op_class,
   output logic [1:0] rs1_sel,
   output logic [1:0] rs2_sel,
   output logic       cap_ex1,
   output logic       cap_ex2,
   output logic       is_jalr,
   output logic       is_illegal
);

   logic [2:0] eff_class;

   // Classify the latched op; reserved codes fold to R-type when illegal
   // detection is disabled.
   always_comb begin
      is_illegal = ILLEGAL_EN && is_reserved_class(op_class);
      eff_class  = (!ILLEGAL_EN && is_reserved_class(op_class)) ? OPC_R : op_class;
      is_jalr    = (eff_class == OPC_JALR);
   end

   // Drive operand selects per state; idle/done park on rs1 + rs2.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
      rs1_sel = RS1_SEL_RS1;
      rs2_sel = RS2_SEL_RS2;
      cap_ex1 = 1'b0;
      cap_ex2 = 1'b0;
      case (state)
         ST_EX1: begin
            cap_ex1 = 1'b1;
            if (is_illegal) begin
               rs1_sel = RS1_SEL_ZERO;
               rs2_sel = RS2_SEL_RS2;
            end else begin
               case (eff_class)
                  OPC_I, OPC_LOAD, OPC_JALR: rs2_sel = RS2_SEL_IMM_I;
                  OPC_STORE:                 rs2_sel = RS2_SEL_IMM_S;
                  default:                   rs2_sel = RS2_SEL_RS2;
               endcase
            end
         end
         ST_EX2: begin
            cap_ex2 = 1'b1;
            rs1_sel = RS1_SEL_FOUR;
            rs2_sel = RS2_SEL_PC;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer: accepts one decoded instruction, steers the shared
// ALU through one (or two, for JALR) cycles and hands the result to writeback.
module alu_exec_seq
   import alu_ctrl_pkg::*;
#(
   parameter int TAG_W      = 4,
   parameter bit ILLEGAL_EN = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [2:0]       io_op_class,
   input  logic [TAG_W-1:0] io_in_tag,
   input  logic             io_flush,
   output logic [1:0]       io_rs2_mux_sel,
   output logic [1:0]       io_rs1_mux_sel,
   input  logic [31:0]      io_alu_result,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [31:0]      io_out_result,
   output logic [31:0]      io_out_target,
   output logic [TAG_W-1:0] io_out_tag,
   output logic             io_out_illegal,
   output logic             io_busy
);

   state_e     state, state_nxt;
   logic [2:0] op_class_q;
   logic       accept;
   logic       cap_ex1, cap_ex2, is_jalr, is_illegal;

   alu_exec_sel_decode #(
      .ILLEGAL_EN (ILLEGAL_EN)
   ) u_decode (
      .state      (state),
      .op_class   (op_class_q),
      .rs1_sel    (io_rs1_mux_sel),
      .rs2_sel    (io_rs2_mux_sel),
      .cap_ex1    (cap_ex1),
      .cap_ex2    (cap_ex2),
      .is_jalr    (is_jalr),
      .is_illegal (is_illegal)
   );

   // Handshake: ready when idle or when the finished result leaves this cycle.
   always_comb begin
      io_in_ready  = reset && !io_flush &&
                     ((state == ST_IDLE) || (state == ST_DONE && io_out_ready));
      accept       = io_in_valid && io_in_ready;
      io_out_valid = (state == ST_DONE);
      io_busy      = (state != ST_IDLE);
   end

   // Next-state logic; flush wins over every other transition.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_EX1;
         ST_EX1:  state_nxt = is_jalr ? ST_EX2 : ST_DONE;
         ST_EX2:  state_nxt = ST_DONE;
         ST_DONE: if (io_out_ready) state_nxt = accept ? ST_EX1 : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (io_flush) state_nxt = ST_IDLE;
   end

   // State, latched instruction info and captured ALU results.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state          <= ST_IDLE;
         op_class_q     <= OPC_R;
         io_out_tag     <= '0;
         io_out_result  <= '0;
         io_out_target  <= '0;
         io_out_illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_class_q <= io_op_class;
            io_out_tag <= io_in_tag;
         end
         // A flushed instruction captures nothing; previous results stay put.
         if (!io_flush) begin
            if (cap_ex1) begin
               io_out_illegal <= is_illegal;
               io_out_target  <= is_jalr ? (io_alu_result & TARGET_MASK) : 32'h0;
               if (!is_jalr) io_out_result <= is_illegal ? 32'h0 : io_alu_result;
            end
            if (cap_ex2) io_out_result <= io_alu_result;
         end
      end
   end

endmodule
